// File: rtl/stack_adder.sv
// Stack-pointer address adder: registered push (decrement), pop (increment) or pass-through.
// Optional bounds clamping and bound_err flag are enabled by defining STACK_BOUNDS_EN.
module stack_adder #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] STEP    = 1,
  parameter logic [WIDTH-1:0] SP_LOW  = '0,
  parameter logic [WIDTH-1:0] SP_HIGH = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_op,
  input  logic             push_pop,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             bound_err
);

  localparam logic [WIDTH:0] STEP_X = {1'b0, STEP};

  if (STEP == '0) begin : g_bad_step
    $error("stack_adder: STEP must be nonzero");
  end
  if (SP_LOW > SP_HIGH) begin : g_bad_bounds
    $error("stack_adder: SP_LOW must not exceed SP_HIGH");
  end

  // One extra bit keeps the unwrapped result: its MSB is the borrow/carry.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_calc;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_bound_err;

  assign w_sum  = {1'b0, in} + STEP_X;
  assign w_diff = {1'b0, in} - STEP_X;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_calc      = {1'b0, in};
    w_wrap      = 1'b0;
    w_next      = in;
    w_bound_err = 1'b0;
    if (stack_op) begin
      w_calc = push_pop ? w_diff : w_sum;
      w_wrap = w_calc[WIDTH];
      w_next = w_calc[WIDTH-1:0];
`ifdef STACK_BOUNDS_EN
      // A wrapped result sits at or above 2^WIDTH here, so it always exceeds SP_HIGH.
      if ((w_calc < {1'b0, SP_LOW}) || (w_calc > {1'b0, SP_HIGH})) begin
        w_next      = in;
        w_bound_err = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      wrap      <= 1'b0;
      bound_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out       <= w_next;
      wrap      <= w_wrap;
      bound_err <= w_bound_err;
    end
  end

endmodule

// File: tb/tb_stack_adder.sv
// Directed self-checking bench for stack_adder; bounds vectors apply when STACK_BOUNDS_EN is defined.
module tb_stack_adder;

  logic        clk;
  logic        rst;
  logic        stack_op;
  logic        push_pop;
  logic [31:0] in_v;
  logic [31:0] out_v;
  logic        wrap;
  logic        bound_err;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        op;
    logic        pp;
    logic [31:0] in;
    logic [31:0] out;
    logic        wrap;
    logic        berr;
  } vec_t;

  stack_adder #(
    .WIDTH  (32),
    .STEP   (32'd1),
    .SP_LOW (32'd16),
    .SP_HIGH(32'd64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stack_op (stack_op),
    .push_pop (push_pop),
    .in       (in_v),
    .out      (out_v),
    .wrap     (wrap),
    .bound_err(bound_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic op, input logic pp, input logic [31:0] v);
    @(negedge clk);
    stack_op = op;
    push_pop = pp;
    in_v     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    stack_op = 1'b1;
    push_pop = 1'b0;
    in_v     = 32'd3;
    #2;
    tests_run++;
    if ({out_v, wrap, bound_err} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got out=%h wrap=%b berr=%b, want 0/0/0", out_v, wrap, bound_err);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out_v, wrap, bound_err} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_held: got out=%h wrap=%b berr=%b, want 0/0/0", out_v, wrap, bound_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    vec_t v[4];
    v[0] = '{1'b0, 1'b1, 32'd3,          32'd3,          1'b0, 1'b0};
    v[1] = '{1'b0, 1'bx, 32'd0,          32'd0,          1'b0, 1'b0};
    v[2] = '{1'b0, 1'bx, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0};
    v[3] = '{1'b0, 1'b0, 32'h1234_5678,  32'h1234_5678,  1'b0, 1'b0};
    foreach (v[i]) begin
      step(v[i].op, v[i].pp, v[i].in);
      tests_run++;
      if ({out_v, wrap, bound_err} !== {v[i].out, v[i].wrap, v[i].berr}) begin
        tests_failed++;
        $display("FAIL pass_through[%0d]: got out=%h wrap=%b berr=%b, want out=%h wrap=%b berr=%b",
                 i, out_v, wrap, bound_err, v[i].out, v[i].wrap, v[i].berr);
      end
    end
  endtask

  task automatic test_push_pop();
    vec_t v[4];
    v[0] = '{1'b1, 1'b1, 32'd3,    32'd2,    1'b0, 1'b0};
    v[1] = '{1'b1, 1'b0, 32'd3,    32'd4,    1'b0, 1'b0};
    v[2] = '{1'b1, 1'b1, 32'd1000, 32'd999,  1'b0, 1'b0};
    v[3] = '{1'b1, 1'b0, 32'hFF,   32'h100,  1'b0, 1'b0};
    foreach (v[i]) begin
      step(v[i].op, v[i].pp, v[i].in);
      tests_run++;
      if ({out_v, wrap, bound_err} !== {v[i].out, v[i].wrap, v[i].berr}) begin
        tests_failed++;
        $display("FAIL push_pop[%0d]: got out=%h wrap=%b berr=%b, want out=%h wrap=%b berr=%b",
                 i, out_v, wrap, bound_err, v[i].out, v[i].wrap, v[i].berr);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[5];
    v[0] = '{1'b1, 1'b1, 32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0};
    v[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
    v[2] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[3] = '{1'b1, 1'b1, 32'd1,         32'd0,         1'b0, 1'b0};
    v[4] = '{1'b0, 1'b1, 32'd0,         32'd0,         1'b0, 1'b0};
    foreach (v[i]) begin
      step(v[i].op, v[i].pp, v[i].in);
      tests_run++;
      if ({out_v, wrap, bound_err} !== {v[i].out, v[i].wrap, v[i].berr}) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got out=%h wrap=%b berr=%b, want out=%h wrap=%b berr=%b",
                 i, out_v, wrap, bound_err, v[i].out, v[i].wrap, v[i].berr);
      end
    end
  endtask

  task automatic test_bounds();
    vec_t v[6];
    v[0] = '{1'b1, 1'b1, 32'd16, 32'd16, 1'b0, 1'b1};
    v[1] = '{1'b1, 1'b0, 32'd40, 32'd41, 1'b0, 1'b0};
    v[2] = '{1'b1, 1'b0, 32'd64, 32'd64, 1'b0, 1'b1};
    v[3] = '{1'b1, 1'b1, 32'd17, 32'd16, 1'b0, 1'b0};
    v[4] = '{1'b1, 1'b1, 32'd0,  32'd0,  1'b1, 1'b1};
    v[5] = '{1'b0, 1'b1, 32'd3,  32'd3,  1'b0, 1'b0};
    foreach (v[i]) begin
      step(v[i].op, v[i].pp, v[i].in);
      tests_run++;
      if ({out_v, wrap, bound_err} !== {v[i].out, v[i].wrap, v[i].berr}) begin
        tests_failed++;
        $display("FAIL bounds[%0d]: got out=%h wrap=%b berr=%b, want out=%h wrap=%b berr=%b",
                 i, out_v, wrap, bound_err, v[i].out, v[i].wrap, v[i].berr);
      end
    end
  endtask

  task automatic test_async_reset();
`ifdef STACK_BOUNDS_EN
    logic [31:0] start = 32'd40;
    logic [31:0] exp   = 32'd39;
`else
    logic [31:0] start = 32'd100;
    logic [31:0] exp   = 32'd99;
`endif
    step(1'b1, 1'b1, start);
    tests_run++;
    if (out_v !== exp) begin
      tests_failed++;
      $display("FAIL async_pre: got out=%h, want %h", out_v, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_v, wrap, bound_err} !== 34'd0) begin
      tests_failed++;
      $display("FAIL async_assert: got out=%h wrap=%b berr=%b, want 0/0/0", out_v, wrap, bound_err);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({out_v, wrap, bound_err} !== {exp, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_release: got out=%h wrap=%b berr=%b, want out=%h wrap=0 berr=0",
               out_v, wrap, bound_err, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_pass_through();
`ifdef STACK_BOUNDS_EN
    test_bounds();
`else
    test_push_pop();
    test_wrap();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stack_adder.md
Name: stack_adder

Overview:
- Stack-pointer address adder in the memory/execute path of the five-stage pipeline.
- Takes the current stack pointer and produces the next address: decremented on push, incremented on pop, passed through unchanged on a non-stack instruction.
- Output is registered on the pipeline clock, with wrap-detect status flags for the hazard/exception logic.

Parameters:
- WIDTH, 32, bit width of the pointer input and address output.
- STEP, 1, amount added or subtracted per stack operation; unsigned; must satisfy 1 <= STEP < 2^WIDTH.
- SP_LOW, 0, lowest legal stack address; used only when STACK_BOUNDS_EN is defined.
- SP_HIGH, 2^WIDTH-1, highest legal stack address; used only when STACK_BOUNDS_EN is defined.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- stack_op  input  1  1 = current instruction is a stack operation; 0 = pass-through.
- push_pop  input  1  meaningful only when stack_op=1; 1 = push (decrement), 0 = pop (increment).
- in  input  WIDTH  current stack pointer value.
- out  output  WIDTH  registered next address.
- wrap  output  1  registered; 1 when the last computed stack operation wrapped modulo 2^WIDTH.
- bound_err  output  1  registered; bounds violation flag (see Optional Feature).

Behaviour:
- Reset:
  - While rst=1 (asynchronous, no clock needed): out=0, wrap=0, bound_err=0.
  - Deassertion takes effect at the next rising edge.
- Latency: one cycle. At each rising edge with rst=0, out takes:
  - stack_op=0: in (push_pop ignored).
  - stack_op=1, push_pop=1: (in - STEP) mod 2^WIDTH.
  - stack_op=1, push_pop=0: (in + STEP) mod 2^WIDTH.
- No handshake: a new value is computed every cycle; no enable and no stall input.
- Arithmetic: unsigned, WIDTH bits.
- wrap is registered with out:
  - push with in < STEP: wrap=1.
  - pop with in > 2^WIDTH-1-STEP: wrap=1.
  - Otherwise 0, including whenever stack_op=0.
- Boundary cases:
  - in=0 on push: out=2^WIDTH-STEP, wrap=1.
  - in=all-ones on pop: out=STEP-1, wrap=1.
  - in=0 or all-ones with stack_op=0: passed through, wrap=0.
- Inputs change only between edges; no internal state beyond the output registers.
- Reset mid-operation discards the pending result; the first edge after release computes from the current inputs.
- X on push_pop is tolerated when stack_op=0.

Optional Feature:
- Macro: STACK_BOUNDS_EN.
- Defined:
  - A stack operation whose mathematical (unwrapped) result lies outside [SP_LOW, SP_HIGH] does not move the pointer; out=in.
  - bound_err=1 for that cycle.
  - wrap keeps its normal definition (still flags the arithmetic wrap).
  - Legal results set bound_err=0.
  - Pass-through cycles always set bound_err=0 and are never clamped.
- Undefined:
  - No bounds logic.
  - bound_err is tied to 0.
  - SP_LOW/SP_HIGH are unused.
  - Wrapping results are output as computed.

Test Plan:
- Pass-through: rst pulse, then in=3, stack_op=0, push_pop=1; after 1 edge -> out=3, wrap=0, bound_err=0.
- Push: in=3, stack_op=1, push_pop=1 -> out=2 after next edge, wrap=0.
- Pop: in=3, stack_op=1, push_pop=0 -> out=4 after next edge, wrap=0.
- Wrap, macro undefined:
  - in=0 push -> out=32'hFFFF_FFFF, wrap=1.
  - in=32'hFFFF_FFFF pop -> out=0, wrap=1.
- Async reset: drive push with in=100, assert rst mid-cycle -> out=0 immediately without a clock edge; release, then next edge -> out=99.
- STACK_BOUNDS_EN with SP_LOW=16, SP_HIGH=64:
  - in=16 push -> out=16, bound_err=1.
  - in=40 pop -> out=41, bound_err=0.
  - in=64 pop -> out=64, bound_err=1.
